change_dispense_ctrl: RTL and testbench
=======================================

CHANGE_DISPENSE_CTRL -- requirements
Module: change_dispense_ctrl

Interface
REQ-001 Parameter NICKEL_INIT, default 8: nickel inventory loaded at reset/refill; range 0-15.
REQ-002 Parameter DIME_INIT, default 8: dime inventory loaded at reset/refill; range 0-15.
REQ-003 Parameter ACK_TIMEOUT, default 15: maximum cycles an eject may wait for hop_ack; range 1-15.
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  1  start a payout; sampled only in IDLE.
REQ-007 amount  input  3  change owed in 5-cent units (0-7), latched when req is accepted.
REQ-008 refill  input  1  reload inventories to NICKEL_INIT/DIME_INIT; honoured only in IDLE.
REQ-009 hop_ack  input  1  hopper confirms the requested coin was ejected.
REQ-010 eject_n  output  1  nickel eject request, level, held until ack or timeout.
REQ-011 eject_d  output  1  dime eject request, level, held until ack or timeout.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  2  status valid with done: 00 ok, 01 insufficient coins, 10 hopper timeout; holds last value otherwise.
REQ-015 nickels  output  4  current nickel inventory.
REQ-016 dimes  output  4  current dime inventory.

Function
REQ-017 All outputs SHALL be registered; states: IDLE, PLAN, SEL, EJECT, FINISH.
REQ-018 IDLE: refill=1 SHALL reload both inventories and ignore req in that cycle; else req=1 SHALL latch amount into 3-bit rem and go to PLAN.
REQ-019 PLAN (one cycle): d=min(dimes, rem/2); if rem-2d > nickels, SHALL go to FINISH with err=01 and eject nothing (no partial payout); else go to SEL.
REQ-020 SEL (one cycle, both ejects low): rem=0 -> FINISH err=00; rem>=2 and dimes>0 -> EJECT dime; else EJECT nickel.
REQ-021 EJECT SHALL hold exactly one of eject_d/eject_n high and count cycles from 1.
REQ-022 hop_ack=1 in EJECT SHALL decrement the matching inventory by 1, rem by 2 (dime) or 1 (nickel), and return to SEL; ejects low the following cycle.
REQ-023 Count reaching ACK_TIMEOUT without ack SHALL go to FINISH with err=10; inventory and rem unchanged for that coin; remaining coins abandoned.
REQ-024 FINISH (one cycle): done=1, then IDLE; busy drops the cycle after done.
REQ-025 hop_ack outside EJECT, req outside IDLE, refill outside IDLE SHALL be ignored.
REQ-026 amount=0: req accepted at edge k -> PLAN -> SEL -> done high in cycle k+3, err=00, no eject.
REQ-027 Inventory SHALL never underflow; greedy dimes-first selection is guaranteed to succeed after PLAN passes.
REQ-028 Minimum per-coin cost: SEL 1 cycle + EJECT >=1 cycle (ack in first EJECT cycle).

Reset
REQ-029 reset SHALL force IDLE, eject_n=eject_d=0, busy=0, done=0, err=00, rem=0, nickels=NICKEL_INIT, dimes=DIME_INIT.
REQ-030 reset during any state, including EJECT with ack pending, SHALL take priority over all other inputs; no decrement for the in-flight coin.

Verification
REQ-031 Defaults, req amount=3, ack 2 cycles after each eject rise -> eject_d then eject_n, done err=00, dimes=7, nickels=7.
REQ-032 req amount=0 -> done exactly 3 cycles after req edge, err=00, no eject, counts 8/8.
REQ-033 NICKEL_INIT=2, DIME_INIT=1: amount=4 -> d,n,n, err=00, counts 0/0; then refill, amount=5 -> err=01, no eject, counts 2/1.
REQ-034 Defaults, amount=2, hop_ack held 0 -> eject_d high 15 cycles, done err=10, dimes=8.
REQ-035 reset asserted in EJECT cycle with hop_ack=1 -> next cycle IDLE, ejects low, counts 8/8.
REQ-036 refill and req same IDLE cycle -> inventories reloaded, busy stays 0; stray hop_ack in IDLE -> no count change.

Source files
------------

// File: rtl/change_dispense_ctrl.sv
// rtl/change_dispense_ctrl.sv - coin change payout controller driving a nickel/dime hopper
module change_dispense_ctrl #(
    parameter int NICKEL_INIT = 8,
    parameter int DIME_INIT   = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req,
    input  logic [2:0] amount,
    input  logic       refill,
    input  logic       hop_ack,
    output logic       eject_n,
    output logic       eject_d,
    output logic       busy,
    output logic       done,
    output logic [1:0] err,
    output logic [3:0] nickels,
    output logic [3:0] dimes
);

    typedef enum logic [2:0] {IDLE, PLAN, SEL, EJECT, FINISH} state_t;

    state_t     state, state_d;
    logic [2:0] rem, rem_d;
    logic [3:0] cnt, cnt_d;
    logic       coin_dime, coin_dime_d;
    logic [3:0] nickels_d, dimes_d;
    logic [1:0] err_d;
    logic [1:0] half;
    logic [1:0] dimes_used;
    logic [3:0] nickels_need;

    // Feasibility check: take as many dimes as fit, the rest must be covered by nickels.
    always_comb begin
        half         = rem[2:1];
        dimes_used   = (dimes > {2'b00, half}) ? half : dimes[1:0];
        nickels_need = {1'b0, rem} - {1'b0, dimes_used, 1'b0};
    end

    always_comb begin
        state_d     = state;
        rem_d       = rem;
        cnt_d       = cnt;
        coin_dime_d = coin_dime;
        nickels_d   = nickels;
        dimes_d     = dimes;
        err_d       = err;
        case (state)
            IDLE: begin
                if (refill) begin
                    nickels_d = 4'(NICKEL_INIT);
                    dimes_d   = 4'(DIME_INIT);
                end else if (req) begin
                    rem_d   = amount;
                    state_d = PLAN;
                end
            end
            PLAN: begin
                if (nickels_need > nickels) begin
                    err_d   = 2'b01;
                    state_d = FINISH;
                end else begin
                    state_d = SEL;
                end
            end
            SEL: begin
                if (rem == 3'd0) begin
                    err_d   = 2'b00;
                    state_d = FINISH;
                end else begin
                    coin_dime_d = (rem >= 3'd2) && (dimes != 4'd0);
                    cnt_d       = 4'd1;
                    state_d     = EJECT;
                end
            end
            EJECT: begin
                if (hop_ack) begin
                    if (coin_dime) begin
                        dimes_d = dimes - 4'd1;
                        rem_d   = rem - 3'd2;
                    end else begin
                        nickels_d = nickels - 4'd1;
                        rem_d     = rem - 3'd1;
                    end
                    state_d = SEL;
                end else if (cnt == 4'(ACK_TIMEOUT)) begin
                    err_d   = 2'b10;
                    state_d = FINISH;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from the next state so they change together with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            rem       <= 3'd0;
            cnt       <= 4'd0;
            coin_dime <= 1'b0;
            nickels   <= 4'(NICKEL_INIT);
            dimes     <= 4'(DIME_INIT);
            err       <= 2'b00;
            done      <= 1'b0;
            busy      <= 1'b0;
            eject_d   <= 1'b0;
            eject_n   <= 1'b0;
        end else begin
            state     <= state_d;
            rem       <= rem_d;
            cnt       <= cnt_d;
            coin_dime <= coin_dime_d;
            nickels   <= nickels_d;
            dimes     <= dimes_d;
            err       <= err_d;
            done      <= (state_d == FINISH);
            busy      <= (state_d != IDLE);
            eject_d   <= (state_d == EJECT) && coin_dime_d;
            eject_n   <= (state_d == EJECT) && !coin_dime_d;
        end
    end

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// tb/tb_change_dispense_ctrl.sv - randomized self-checking bench for change_dispense_ctrl
module tb_change_dispense_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       req = 1'b0;
    logic [2:0] amount = 3'd0;
    logic       refill = 1'b0;
    logic       hop_ack = 1'b0;
    logic       eject_n, eject_d, busy, done;
    logic [1:0] err;
    logic [3:0] nickels, dimes;

    change_dispense_ctrl dut (
        .clock(clock), .reset(reset), .req(req), .amount(amount), .refill(refill),
        .hop_ack(hop_ack), .eject_n(eject_n), .eject_d(eject_d), .busy(busy),
        .done(done), .err(err), .nickels(nickels), .dimes(dimes)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int ref_n = 8;
    int ref_d = 8;
    bit got_coins[$];
    logic [1:0] got_err;
    bit got_done;
    int run_len;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drives one payout, acting as the hopper; fail_idx names the coin left unacknowledged.
    task automatic run_payout(input logic [2:0] amt, input int fail_idx, input int fixed_dly, input bit noise);
        int ecyc, coin_i, dly;
        bit prev;
        got_coins.delete();
        got_done = 0; got_err = 2'b00; run_len = 0;
        ecyc = 0; coin_i = -1; dly = 1; prev = 0;
        @(negedge clock);
        req = 1'b1; amount = amt;
        step();
        req = 1'b0; amount = 3'($urandom);
        for (int c = 0; c < 300 && !got_done; c++) begin
            n_cmp++;
            if (eject_d && eject_n) begin
                n_bad++;
                $display("FAIL both_ejects got eject_d=%0b eject_n=%0b required one-hot", eject_d, eject_n);
            end
            if (done) begin
                got_done = 1;
                got_err  = err;
            end else if (eject_d || eject_n) begin
                if (!prev) begin
                    got_coins.push_back(eject_d);
                    coin_i++;
                    ecyc = 0;
                    dly = (fixed_dly != 0) ? fixed_dly : int'($urandom_range(1, 3));
                end
                ecyc++;
                run_len = ecyc;
                hop_ack = (coin_i != fail_idx) && (ecyc == dly);
            end else begin
                hop_ack = noise ? 1'($urandom % 2) : 1'b0;
            end
            prev = eject_d || eject_n;
            if (noise) begin
                refill = ($urandom % 3 == 0);
                req    = ($urandom % 3 == 0);
                amount = 3'($urandom);
            end
            if (!got_done) step();
        end
        hop_ack = 1'b0; req = 1'b0; refill = 1'b0;
    endtask

    task automatic check_payout(input string tag, input int amt, input int fail_idx);
        bit exp[$];
        int k, need, last;
        logic [1:0] exp_err;
        bit seq_ok;
        k = (ref_d < amt / 2) ? ref_d : amt / 2;
        need = amt - 2 * k;
        if (need > ref_n) begin
            exp_err = 2'b01;
        end else begin
            for (int i = 0; i < k; i++) exp.push_back(1'b1);
            for (int i = 0; i < need; i++) exp.push_back(1'b0);
            exp_err = 2'b00;
            last = exp.size();
            if (fail_idx >= 0 && fail_idx < exp.size()) begin
                exp_err = 2'b10;
                last = fail_idx;
                while (exp.size() > fail_idx + 1) exp.pop_back();
            end
            for (int i = 0; i < last; i++) begin
                if (exp[i]) ref_d--; else ref_n--;
            end
        end
        n_cmp++;
        if (!got_done) begin
            n_bad++;
            $display("FAIL %s done_seen got 0 required 1 within 300 cycles", tag);
        end
        n_cmp++;
        if (got_err !== exp_err) begin
            n_bad++;
            $display("FAIL %s err got %b required %b (amt=%0d)", tag, got_err, exp_err, amt);
        end
        seq_ok = (got_coins.size() == exp.size());
        if (seq_ok) for (int i = 0; i < exp.size(); i++) if (got_coins[i] != exp[i]) seq_ok = 0;
        n_cmp++;
        if (!seq_ok) begin
            n_bad++;
            $display("FAIL %s coins got %p required %p (1=dime)", tag, got_coins, exp);
        end
        step();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after_done got busy=%b done=%b required 0/0", tag, busy, done);
        end
        n_cmp++;
        if (nickels !== 4'(ref_n) || dimes !== 4'(ref_d)) begin
            n_bad++;
            $display("FAIL %s counts got n=%0d d=%0d required n=%0d d=%0d", tag, nickels, dimes, ref_n, ref_d);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        n_cmp++;
        if ({eject_n, eject_d, busy, done, err} !== 6'b0 || nickels !== 4'd8 || dimes !== 4'd8) begin
            n_bad++;
            $display("FAIL reset got ej_n=%b ej_d=%b busy=%b done=%b err=%b n=%0d d=%0d required 0s and 8/8",
                     eject_n, eject_d, busy, done, err, nickels, dimes);
        end
        ref_n = 8; ref_d = 8;
    endtask

    task automatic test_zero();
        logic exp_done[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic exp_busy[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        @(negedge clock);
        req = 1'b1; amount = 3'd0;
        for (int c = 0; c < 4; c++) begin
            step();
            req = 1'b0;
            n_cmp++;
            if (done !== exp_done[c] || busy !== exp_busy[c] || eject_d || eject_n) begin
                n_bad++;
                $display("FAIL zero_timing edge%0d got done=%b busy=%b ej=%b%b required done=%b busy=%b ej=00",
                         c, done, busy, eject_d, eject_n, exp_done[c], exp_busy[c]);
            end
            if (c == 2) begin
                n_cmp++;
                if (err !== 2'b00) begin
                    n_bad++;
                    $display("FAIL zero_err got %b required 00", err);
                end
            end
        end
        n_cmp++;
        if (nickels !== 4'd8 || dimes !== 4'd8) begin
            n_bad++;
            $display("FAIL zero_counts got n=%0d d=%0d required 8/8", nickels, dimes);
        end
    endtask

    task automatic test_basic();
        run_payout(3'd3, -1, 2, 0);
        check_payout("basic_amt3", 3, -1);
    endtask

    task automatic test_timeout();
        run_payout(3'd2, 0, 2, 0);
        n_cmp++;
        if (run_len != 15) begin
            n_bad++;
            $display("FAIL timeout_len got %0d cycles required 15", run_len);
        end
        check_payout("timeout_amt2", 2, 0);
    endtask

    task automatic test_insufficient();
        int amts[6] = '{7, 7, 7, 7, 3, 1};
        @(negedge clock);
        refill = 1'b1;
        step();
        refill = 1'b0;
        ref_n = 8; ref_d = 8;
        foreach (amts[i]) begin
            run_payout(3'(amts[i]), -1, 0, 0);
            check_payout($sformatf("drain%0d", i), amts[i], -1);
        end
    endtask

    task automatic test_refill_req();
        @(negedge clock);
        refill = 1'b1; req = 1'b1; amount = 3'd5;
        step();
        refill = 1'b0; req = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || nickels !== 4'd8 || dimes !== 4'd8) begin
            n_bad++;
            $display("FAIL refill_req got busy=%b n=%0d d=%0d required 0 8/8", busy, nickels, dimes);
        end
        hop_ack = 1'b1;
        step(); step(); step();
        hop_ack = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || nickels !== 4'd8 || dimes !== 4'd8) begin
            n_bad++;
            $display("FAIL stray_ack got busy=%b n=%0d d=%0d required 0 8/8", busy, nickels, dimes);
        end
        ref_n = 8; ref_d = 8;
    endtask

    task automatic test_reset_in_eject();
        bit seen;
        run_payout(3'd3, -1, 1, 0);
        check_payout("pre_reset_amt3", 3, -1);
        @(negedge clock);
        req = 1'b1; amount = 3'd2;
        step();
        req = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (eject_d) seen = 1; else step();
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL reset_eject_rise got no eject_d within 10 cycles required eject_d=1");
        end
        hop_ack = 1'b1; reset = 1'b1;
        step();
        hop_ack = 1'b0; reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || eject_d || eject_n || done || nickels !== 4'd8 || dimes !== 4'd8) begin
            n_bad++;
            $display("FAIL reset_eject got busy=%b ej=%b%b done=%b n=%0d d=%0d required idle 8/8",
                     busy, eject_d, eject_n, done, nickels, dimes);
        end
        step();
        n_cmp++;
        if (busy !== 1'b0 || eject_d || eject_n) begin
            n_bad++;
            $display("FAIL reset_eject_after got busy=%b ej=%b%b required 0", busy, eject_d, eject_n);
        end
        ref_n = 8; ref_d = 8;
    endtask

    task automatic test_random();
        int amt, fail;
        for (int it = 0; it < 40; it++) begin
            if ($urandom % 5 == 0) begin
                @(negedge clock);
                refill = 1'b1;
                step();
                refill = 1'b0;
                ref_n = 8; ref_d = 8;
            end
            amt  = int'($urandom_range(0, 7));
            fail = ($urandom % 6 == 0) ? int'($urandom_range(0, 3)) : -1;
            run_payout(3'(amt), fail, 0, 1);
            check_payout($sformatf("rand%0d", it), amt, fail);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_basic();
        test_timeout();
        test_insufficient();
        test_refill_req();
        test_reset_in_eject();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
